// File: rtl/aes_key_expand.sv
// Iterative AES-128 key expansion: after start, one round key is written per clock
// into an 11-slot schedule register, which is exposed flat and through a per-round read port.
module aes_key_expand #(
  parameter int NR    = 10,
  parameter int KEY_W = 128
) (
  input  logic                      eph1,
  input  logic                      reset,
  input  logic                      start,
  input  logic [KEY_W-1:0]          key_in,
  input  logic [3:0]                rd_round,
  output logic                      busy,
  output logic                      done,
  output logic                      key_valid,
  output logic [(NR+1)*KEY_W-1:0]   key_schedule,
  output logic [KEY_W-1:0]          rd_key
);

  localparam logic [3:0] LAST_ROUND = 4'(NR);

  localparam logic [0:255][7:0] SBOX = {
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  typedef enum logic [1:0] {S_IDLE, S_EXPAND, S_DONE} state_t;

  state_t           state_reg, state_next;
  logic [3:0]       round_reg;
  logic [7:0]       rcon_reg;
  logic             key_valid_reg;
  logic             load, step, last;
  logic [KEY_W-1:0] prev_key, new_key;
  logic [31:0]      p0, p1, p2, p3, rot, g;
  logic [31:0]      w0, w1, w2, w3;

  assign load = (state_reg == S_IDLE) && start;
  assign step = (state_reg == S_EXPAND);
  assign last = step && (round_reg == LAST_ROUND);

  always_ff @(posedge eph1 or posedge reset) begin
    if (reset) state_reg <= S_IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:   if (start) state_next = S_EXPAND;
      S_EXPAND: if (last)  state_next = S_DONE;
      S_DONE:   state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_reg == S_EXPAND);
    done = (state_reg == S_DONE);
  end

  assign key_valid = key_valid_reg;

  always_ff @(posedge eph1 or posedge reset) begin
    if (reset) begin
      round_reg     <= 4'd0;
      rcon_reg      <= 8'h01;
      key_valid_reg <= 1'b0;
    end else if (load) begin
      round_reg     <= 4'd1;
      rcon_reg      <= 8'h01;
      key_valid_reg <= 1'b0;
    end else if (step) begin
      round_reg <= round_reg + 4'd1;
      rcon_reg  <= {rcon_reg[6:0], 1'b0} ^ (rcon_reg[7] ? 8'h1b : 8'h00);
      if (last) key_valid_reg <= 1'b1;
    end
  end

  // The slot being produced is always round_reg, so its source is slot round_reg-1.
  always_comb begin
    prev_key = '0;
    for (int i = 0; i < NR; i++) begin
      if (round_reg == 4'(i + 1)) prev_key = key_schedule[i*KEY_W +: KEY_W];
    end
  end

  assign p0  = prev_key[127:96];
  assign p1  = prev_key[95:64];
  assign p2  = prev_key[63:32];
  assign p3  = prev_key[31:0];
  assign rot = {p3[23:0], p3[31:24]};
  assign g   = {SBOX[rot[31:24]] ^ rcon_reg, SBOX[rot[23:16]], SBOX[rot[15:8]], SBOX[rot[7:0]]};
  assign w0  = p0 ^ g;
  assign w1  = w0 ^ p1;
  assign w2  = w1 ^ p2;
  assign w3  = w2 ^ p3;
  assign new_key = {w0, w1, w2, w3};

  genvar gi;
  generate
    for (gi = 0; gi <= NR; gi++) begin : g_slot
      logic [KEY_W-1:0] slot_reg;
      if (gi == 0) begin : g_seed
        always_ff @(posedge eph1 or posedge reset) begin
          if (reset)     slot_reg <= '0;
          else if (load) slot_reg <= key_in;
        end
      end else begin : g_round
        always_ff @(posedge eph1 or posedge reset) begin
          if (reset)                                 slot_reg <= '0;
          else if (step && round_reg == 4'(gi))      slot_reg <= new_key;
        end
      end
      assign key_schedule[gi*KEY_W +: KEY_W] = slot_reg;
    end
  endgenerate

  always_comb begin
    rd_key = '0;
    for (int i = 0; i <= NR; i++) begin
      if (rd_round == 4'(i)) rd_key = key_schedule[i*KEY_W +: KEY_W];
    end
  end

endmodule

// File: doc/aes_key_expand.md
Name: aes_key_expand

Overview:
- Iterative AES-128 key-expansion engine that sits directly upstream of the AES round datapath.
- Takes a 128-bit cipher key and produces all 11 round keys, one new round key per clock.
- Holds the keys in an internal schedule register and presents them as a flat precalculated key schedule, plus a random-access read port per round.
- The round datapath consumes the schedule only after done/key_valid.

Parameters:
- NR, 10, number of expansion rounds; only 10 (AES-128) is supported.
- KEY_W, 128, cipher/round key width in bits; fixed at 128.

Ports:
- eph1  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  1-cycle request; key_in sampled on the same edge.
- key_in  input  128  cipher key; key_in[127:120] is byte b0, word w0 = key_in[127:96].
- rd_round  input  4  round index for the read port (0..10).
- busy  output  1  high while expansion is in progress.
- done  output  1  1-cycle pulse when round key 10 is stored.
- key_valid  output  1  high while the full schedule is valid.
- key_schedule  output  1408  round key r at [128*r +: 128], same byte order as key_in.
- rd_key  output  128  combinational copy of round key rd_round; 0 when rd_round > 10.

Behaviour:
- Reset (async, any state):
  - State goes to IDLE.
  - busy=0, done=0, key_valid=0, key_schedule all 0, round counter 0, rcon=8'h01.
- FSM states: IDLE, EXPAND, DONE.
- IDLE:
  - start=1 at edge T: slot 0 <= key_in, round <= 1, rcon <= 8'h01, busy <= 1, key_valid <= 0, go to EXPAND.
- EXPAND (round r = 1..10):
  - Each edge writes slot r from slot r-1 (prev words p0..p3).
  - g = SubWord(RotWord(p3)) ^ {rcon, 24'h0}. RotWord maps bytes {a,b,c,d} to {b,c,d,a}. SubWord is the standard AES S-box per byte.
  - w0 = p0 ^ g; w1 = w0 ^ p1; w2 = w1 ^ p2; w3 = w2 ^ p3.
  - rcon update: rcon <= xtime(rcon), where xtime = shift left 1, XOR 8'h1b if bit 7 was set. Sequence: 01,02,04,08,10,20,40,80,1b,36.
  - When r = 10 is written: go to DONE, busy <= 0, done <= 1, key_valid <= 1.
- DONE: held for one cycle; done falls to 0 and state returns to IDLE. key_valid stays 1.
- Latency: start sampled at edge T; slot r is written at edge T+r; done and key_valid are high after edge T+10. done lasts exactly 1 cycle.
- Slots are written in place, so intermediate slots are visible on key_schedule/rd_key while busy. Consumers must qualify with key_valid.
- start while busy (EXPAND): ignored; the expansion in flight is unaffected.
- start in the cycle done is high (DONE state): ignored.
- start in IDLE with key_valid=1: new expansion begins and key_valid drops to 0 on that edge. Old slots 1..10 remain until overwritten.
- reset mid-expansion: immediate abort, all outputs as at reset; the next start behaves normally.
- rd_key is purely combinational from the schedule register and rd_round; no handshake.
- S-box: 4 byte lookups per cycle, on the p3 path only.

Test Plan:
- FIPS-197 key: reset, then start with key_in=2b7e151628aed2a6abf7158809cf4f3c.
  - Required: done pulses exactly 10 cycles after start and key_valid=1.
  - Slot 1 = a0fafe1788542cb123a339392a6c7605.
  - Slot 10 = d014f9a8c9ee2589e13f0cc8b6630ca6.
  - rd_round=10 gives rd_key = slot 10; rd_round=15 gives rd_key=0.
- Zero key: start with key_in=0.
  - Required: slot 1 = 62636363626363636263636362636363.
  - Slot 10 = b4ef5bcb3e92e21123e951cf6f8f188e.
- Start during expansion: start with the FIPS key, then pulse start with key_in=0 at cycle T+4.
  - Required: ignored; done at T+10; slot 10 = d014f9a8c9ee2589e13f0cc8b6630ca6.
- Reset mid-operation: assert reset at cycle T+6 of an expansion.
  - Required: busy, done and key_valid go to 0 and key_schedule=0 immediately (asynchronous).
  - A following start with the zero key completes correctly.
- Back-to-back: start the FIPS key, then start the zero key in the first IDLE cycle after done.
  - Required: key_valid drops on that start edge.
  - The second done arrives 10 cycles later with the zero-key vectors.
- Done and busy protocol:
  - Check busy=1 throughout EXPAND and busy=0 in the done cycle.
  - Check done is never high for 2 consecutive cycles.
